inst_buffer: RTL and testbench
==============================

# inst_buffer

Bundle queue between the instruction-fetch stage and decode. It captures each 64-bit two-instruction bundle together with its PC, and holds it while decode is interlocked. It discards everything on a branch redirect and presents NOP bundles whenever it has nothing valid. Fetch's synchronous ROM output cannot be held back after the fact, so this block absorbs the bundles that arrive during the stall-propagation cycle.

## Interface
- DEPTH, 2, number of bundle entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rstn  in  1  synchronous active-low reset
- flush  in  1  branch redirect; discard all stored and incoming bundles
- in_valid  in  1  fetch offers a bundle this cycle
- in_bundle  in  64  bits [63:32] = slot 0 (earlier in program order), [31:0] = slot 1
- in_pc  in  32  PC of slot 0 of in_bundle
- in_ready  out  1  buffer can accept; feeds fetch_stall (fetch_stall = ~in_ready)
- out_ready  in  1  decode consumes head this cycle (= ~interlock)
- out_valid  out  1  head entry valid
- out_inst0  out  32  slot 0 of head, NOP when !out_valid
- out_inst1  out  32  slot 1 of head, NOP when !out_valid
- out_pc  out  32  PC of head, 0 when !out_valid
- count  out  $clog2(DEPTH)+1  number of stored entries

## Operation
- Storage is a circular array of DEPTH entries {bundle, pc}, with head pointer, tail pointer and occupancy count.
- NOP is 32'hE000_0000 (3'b111 opcode, zero fields).
- Push: in_valid && in_ready → write the entry at tail; tail increments mod DEPTH.
- Pop: out_valid && out_ready → head increments mod DEPTH.
- in_ready = (count < DEPTH), derived from registered count only. No combinational path from out_ready.
- out_valid = (count != 0). Outputs are driven from the head entry (flop storage), so there is no in→out combinational path.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, no push occurs even if a pop happens the same cycle.
- flush takes priority over push and pop.
  - Next cycle: count=0, head=tail=0.
  - The same-cycle incoming bundle is dropped.
  - The same-cycle pop still counts as consumed from decode's view; decode is itself flushed.
- Entry contents are not cleared on flush or reset. Output masking by out_valid hides them.
- in_valid while !in_ready: the bundle is ignored. Fetch must hold PC and re-present it.
- Pointers wrap modulo DEPTH. count saturates by construction and never exceeds DEPTH.

## Timing
- Reset (rstn=0 at an edge): count=0, head=0, tail=0.
  - Outputs after reset: out_valid=0, out_inst0=out_inst1=NOP, out_pc=0, in_ready=1.
- Latency: a bundle pushed at edge N is visible on the outputs after edge N (cycle N+1) if the buffer was empty. Minimum latency is 1 cycle and there is no bypass.
- Throughput: one bundle per cycle sustained with out_ready=1 (count steady at 1).
- Stall: out_ready=0 with continuous in_valid fills the buffer. in_ready drops the cycle after count reaches DEPTH.
- Flush: out_valid=0 in the cycle after flush. A push in that cycle is accepted normally.
- Reset during operation behaves identically to flush, plus in_ready is forced to 1 next cycle.

## Structure
- Shared package core_pkg:
  - NOP_INST = 32'hE000_0000
  - typedef bundle_t (64-bit)
  - typedef ibuf_entry_t {bundle_t bundle; logic [31:0] pc;}
- No sub-module. The logic is a single always_ff block for pointers, count and storage, plus continuous assigns for the outputs.

## Test plan
- Reset, then idle. Required: out_valid=0, out_inst0=out_inst1=32'hE000_0000, out_pc=0, in_ready=1, count=0.
- Streaming. Push bundles PC=0x0,0x8,0x10 on consecutive cycles with out_ready=1. Required: same bundles and PCs appear in order, one cycle later each, count constant 1.
- Interlock fill. out_ready=0 and in_valid=1 for 3 cycles (DEPTH=2). Required: count 1→2, in_ready=0 from the third cycle, third bundle not stored. After out_ready=1, the first two bundles drain in order.
- Push and pop while full. Buffer full, out_ready=1, in_valid=1. Required: pop occurs, no push that cycle, count 2→1, in_ready=1 next cycle.
- Flush with concurrent push. Buffer holds 2 entries; flush=1 with in_valid=1 (PC=0x40). Required: next cycle count=0, out_valid=0, NOP outputs. The 0x40 bundle never appears; a push of PC=0x80 the following cycle appears next.
- Pointer wrap. 10 pushes and pops with randomized out_ready. Required: output order matches a scoreboard exactly, and count never exceeds 2.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared fetch/decode types and constants
package core_pkg;
  localparam logic [31:0] NOP_INST = 32'hE000_0000;
  typedef logic [63:0] bundle_t;
  typedef struct packed {
    bundle_t     bundle;
    logic [31:0] pc;
  } ibuf_entry_t;
endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: circular bundle queue between fetch and decode, flushed on redirect
module inst_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [63:0]                in_bundle,
  input  logic [31:0]                in_pc,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [31:0]                out_inst0,
  output logic [31:0]                out_inst1,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  ibuf_entry_t   mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic          push, pop;
  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= '{bundle: in_bundle, pc: in_pc};
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // stale entries stay in storage; out_valid masks them
  assign out_inst0 = out_valid ? mem[head].bundle[63:32] : NOP_INST;
  assign out_inst1 = out_valid ? mem[head].bundle[31:0]  : NOP_INST;
  assign out_pc    = out_valid ? mem[head].pc            : 32'h0;
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: table-driven vectors plus scoreboard for inst_buffer
module tb_inst_buffer;
  import core_pkg::*;
  logic        clk = 0, rstn = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [63:0] in_bundle = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_inst0, out_inst1, out_pc;
  logic [1:0]  count;
  int          checks = 0, failures = 0;
  logic [31:0] sb [$];

  inst_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
    .in_bundle(in_bundle), .in_pc(in_pc), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_inst0(out_inst0),
    .out_inst1(out_inst1), .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {32'h1000_0000 | pc, 32'h2000_0000 ^ (pc << 4)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // one clock: drive, check pre-edge outputs against scoreboard, update model, check count
  task automatic cycle(input logic rs, input logic fl, input logic iv, input logic ordy,
                       input logic [31:0] pc);
    logic        full;
    logic [31:0] e;
    @(negedge clk);
    rstn = !rs; flush = fl; in_valid = iv; out_ready = ordy; in_pc = pc; in_bundle = mk(pc);
    #1;
    full = sb.size() >= 2;
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(!full));
    if (!out_valid) begin
      chk("nop_inst0", 64'(out_inst0), 64'(NOP_INST));
      chk("nop_inst1", 64'(out_inst1), 64'(NOP_INST));
      chk("nop_pc", 64'(out_pc), 64'h0);
    end
    if (out_valid && ordy) begin
      if (sb.size() == 0) chk("pop_on_empty", 64'(out_valid), 64'h0);
      else begin
        e = sb.pop_front();
        chk("sb_pc", 64'(out_pc), 64'(e));
        chk("sb_bundle", {out_inst0, out_inst1}, mk(e));
      end
    end
    if (rs || fl) sb.delete();
    else if (iv && !full) sb.push_back(pc);
    @(posedge clk);
    #1;
    chk("sb_count", 64'(count), 64'(sb.size()));
  endtask

  typedef struct {
    logic        rs, fl, iv, ordy;
    logic [31:0] pc;
    logic [1:0]  e_count;
    logic        e_valid, e_ready;
    logic [31:0] e_pc;
  } vec_t;

  initial begin
    vec_t v [20];
    int   pc;
    v[0]  = '{0,0,1,1,32'h00, 1,1,1,32'h00};
    v[1]  = '{0,0,1,1,32'h08, 1,1,1,32'h08};
    v[2]  = '{0,0,1,1,32'h10, 1,1,1,32'h10};
    v[3]  = '{0,0,0,1,32'h00, 0,0,1,32'h00};
    v[4]  = '{0,0,1,0,32'h18, 1,1,1,32'h18};
    v[5]  = '{0,0,1,0,32'h20, 2,1,0,32'h18};
    v[6]  = '{0,0,1,0,32'h28, 2,1,0,32'h18};
    v[7]  = '{0,0,1,1,32'h28, 1,1,1,32'h20};
    v[8]  = '{0,0,1,0,32'h28, 2,1,0,32'h20};
    v[9]  = '{0,0,0,1,32'h00, 1,1,1,32'h28};
    v[10] = '{0,0,0,1,32'h00, 0,0,1,32'h00};
    v[11] = '{0,0,1,0,32'h30, 1,1,1,32'h30};
    v[12] = '{0,0,1,0,32'h38, 2,1,0,32'h30};
    v[13] = '{0,1,1,0,32'h40, 0,0,1,32'h00};
    v[14] = '{0,0,1,0,32'h80, 1,1,1,32'h80};
    v[15] = '{0,0,0,1,32'h00, 0,0,1,32'h00};
    v[16] = '{0,0,1,0,32'h90, 1,1,1,32'h90};
    v[17] = '{0,1,0,1,32'h00, 0,0,1,32'h00};
    v[18] = '{0,0,1,0,32'hA0, 1,1,1,32'hA0};
    v[19] = '{1,0,1,0,32'hA8, 0,0,1,32'h00};
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_inst0", 64'(out_inst0), 64'hE000_0000);
    chk("rst_inst1", 64'(out_inst1), 64'hE000_0000);
    chk("rst_pc", 64'(out_pc), 64'h0);
    for (int i = 0; i < 20; i++) begin
      cycle(v[i].rs, v[i].fl, v[i].iv, v[i].ordy, v[i].pc);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(v[i].e_count));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(v[i].e_valid));
      chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(v[i].e_ready));
      chk($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(v[i].e_pc));
    end
    pc = 32'h100;
    for (int i = 0; i < 24; i++) begin
      cycle(0, 0, 1, 1'($urandom_range(0, 1)), 32'(pc));
      if (sb.size() > 0 && sb[sb.size()-1] == 32'(pc)) pc += 8;
      chk("count_bound", 64'(count <= 2), 64'h1);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 32'h0);
    chk("drain_count", 64'(count), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
